vrb_arb: RTL and testbench
==========================

# vrb_arb
Two-master to one-slave VRB arbiter. It shares a single memory port between the IFU fetch master (read-only) and the LSU load/store master. It grants one command at a time, tracks the single outstanding transaction, and routes the response back to its owner. A response timeout returns an error instead of hanging the core.
## Interface
- AW, 32, address width
- DW, 32, data width
- TO_W, 8, timeout counter width (≥2); timeout limit TO_MAX = 2^TO_W−1 cycles
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_ifu_cmd_valid  in  1  IFU command request
- i_ifu_cmd_addr  in  AW  IFU fetch address (always a read)
- o_ifu_cmd_ready  out  1  IFU command accepted this cycle when valid&ready
- o_ifu_rsp_valid  out  1  IFU response strobe, 1 cycle
- o_ifu_rsp_err  out  1  IFU response error (slave err or timeout)
- o_ifu_rsp_rdata  out  DW  IFU read data
- i_lsu_cmd_valid  in  1  LSU command request
- i_lsu_cmd_addr  in  AW  LSU address
- i_lsu_cmd_read  in  1  1=read, 0=write
- i_lsu_cmd_wdata  in  DW  LSU write data
- i_lsu_cmd_wmask  in  DW/8  LSU byte mask
- o_lsu_cmd_ready  out  1  LSU command accepted this cycle when valid&ready
- o_lsu_rsp_valid  out  1  LSU response strobe
- o_lsu_rsp_err  out  1  LSU response error
- o_lsu_rsp_rdata  out  DW  LSU read data
- o_vrb_cmd_valid  out  1  slave command strobe, 1 cycle per transaction
- o_vrb_cmd_addr  out  AW  slave address
- o_vrb_cmd_read  out  1  slave read/write
- o_vrb_cmd_wdata  out  DW  slave write data (0 for IFU)
- o_vrb_cmd_wmask  out  DW/8  slave byte mask (0 for IFU)
- i_vrb_rsp_valid  in  1  slave response strobe, at least 1 cycle after the command
- i_vrb_rsp_err  in  1  slave error
- i_vrb_rsp_rdata  in  DW  slave read data
- o_timeout  out  1  1-cycle pulse when a transaction times out
## Operation
- States: IDLE and WAIT. The register `owner` (IFU/LSU) is valid in WAIT only.
- Grant window: the cycle is in IDLE, or it is in WAIT and the transaction completes this cycle (i_vrb_rsp_valid or timeout). At most one ready is high, and only to a requesting master. Outside the window both readies are 0.
- Grant: the command is muxed combinationally to o_vrb_cmd_*, with o_vrb_cmd_valid=1. For IFU, read=1, wdata=0, wmask=0. State goes to WAIT, owner is set, and the counter clears. With no grant, all o_vrb_cmd_* are 0.
- WAIT: the counter increments each cycle. On i_vrb_rsp_valid, rsp_valid/err/rdata are driven to the owner (combinational passthrough) and the other master's rsp outputs stay 0.
- Timeout: when the counter reaches TO_MAX with no response, the owner gets rsp_valid=1, err=1, rdata=0, and o_timeout pulses. If rsp_valid arrives in the same cycle as the timeout, the slave response wins and there is no timeout pulse.
- End of transaction: the state goes to IDLE, or back to WAIT if the grant window re-granted in that cycle.
- Any i_vrb_rsp_valid in IDLE (a late response after a timeout) is dropped.
- Contention default: the LSU always wins.
## Timing
- Reset values: all outputs 0, state IDLE, counter 0, rr pointer = IFU-last.
- Latency: command passthrough is 0 cycles, response passthrough is 0 cycles. With a 1-cycle slave, back-to-back throughput is 1 transaction per cycle after the first.
- Reset asserted during WAIT: the transaction is abandoned, no response is emitted, and all state returns to reset values on the next edge.
## Configuration
- VRB_ARB_RR_EN defined: 2-way round-robin on contention. The master not granted last wins, and the pointer updates on every grant.
- VRB_ARB_RR_EN undefined: fixed LSU priority, and the pointer logic is absent.
## Structure
- Package vrb_pkg holds the state enum (ST_IDLE, ST_WAIT), the master-id enum (M_IFU, M_LSU), and the VRB field widths.
- One sub-module, vrb_arb_pick: combinational grant selection from the two requests, the window and the rr pointer.
## Test plan
- IFU-only read at 0x100, slave responds 2 cycles later with rdata=0xDEADBEEF -> ifu ready the cycle of valid, ifu rsp_valid with 0xDEADBEEF, all LSU outputs 0.
- IFU and LSU request together in IDLE, LSU write to 0x200 with wmask=0xF -> LSU granted first, IFU granted in the cycle the LSU response arrives. With RR_EN, the next contention goes to IFU.
- Slave 1-cycle latency, 4 back-to-back IFU reads -> 4 grants in consecutive cycles after the first response, responses in order.
- No slave response with TO_W=3 -> after 7 WAIT cycles, owner rsp err=1 rdata=0 and o_timeout pulses once. A late rsp_valid in IDLE produces no master response.
- rst pulsed during WAIT, then rsp_valid arrives -> no response to either master, next request granted normally.

Source files
------------

// File: rtl/vrb_pkg.sv
// Shared types and default field widths for the VRB two-master arbiter.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
//
// Contents: arbiter state enum, master-id enum, default VRB field widths.
package vrb_pkg;

    localparam int VRB_AW   = 32;   // address width
    localparam int VRB_DW   = 32;   // data width
    localparam int VRB_TO_W = 8;    // response timeout counter width

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        M_IFU = 1'b0,
        M_LSU = 1'b1
    } master_t;

endpackage

// File: rtl/vrb_arb_pick.sv
// Grant selection between the IFU and LSU command requests.
// Latency: purely combinational, 0 cycles.
// Backpressure: grants only inside the window; at most one grant, only to a requester.
//
// Ports:
//   i_ifu_req / i_lsu_req : command requests from the two masters
//   i_window              : arbiter can accept a new command this cycle
//   i_last                : master granted most recently (VRB_ARB_RR_EN builds only)
//   o_gnt_ifu / o_gnt_lsu : one-hot (or zero) grant
// Macro VRB_ARB_RR_EN selects 2-way round-robin; otherwise LSU has fixed priority.
module vrb_arb_pick
    import vrb_pkg::*;
(
    input  logic    i_ifu_req,
    input  logic    i_lsu_req,
    input  logic    i_window,
`ifdef VRB_ARB_RR_EN
    input  master_t i_last,
`endif
    output logic    o_gnt_ifu,
    output logic    o_gnt_lsu
);

    logic w_lsu_wins;

`ifdef VRB_ARB_RR_EN
    // On contention the master not granted last time wins.
    assign w_lsu_wins = i_lsu_req && (!i_ifu_req || (i_last == M_IFU));
`else
    assign w_lsu_wins = i_lsu_req;
`endif

    assign o_gnt_lsu = i_window && w_lsu_wins;
    assign o_gnt_ifu = i_window && i_ifu_req && !w_lsu_wins;

endmodule

// File: rtl/vrb_arb.sv
// Two-master (IFU fetch, LSU load/store) to one-slave VRB arbiter with response timeout.
// Latency: command and response passthrough are combinational (0 cycles).
// Backpressure: one outstanding transaction; readies only in IDLE or the completing WAIT cycle.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   i_ifu_cmd_* / o_ifu_*   : IFU read-only command and response
//   i_lsu_cmd_* / o_lsu_*   : LSU read/write command and response
//   o_vrb_cmd_* / i_vrb_rsp_*: shared slave port
//   o_timeout               : 1-cycle pulse when an outstanding transaction times out
// Macro VRB_ARB_RR_EN enables round-robin on contention (default: LSU priority).
module vrb_arb
    import vrb_pkg::*;
#(
    parameter int AW   = VRB_AW,
    parameter int DW   = VRB_DW,
    parameter int TO_W = VRB_TO_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_ifu_cmd_valid,
    input  logic [AW-1:0]   i_ifu_cmd_addr,
    output logic            o_ifu_cmd_ready,
    output logic            o_ifu_rsp_valid,
    output logic            o_ifu_rsp_err,
    output logic [DW-1:0]   o_ifu_rsp_rdata,
    input  logic            i_lsu_cmd_valid,
    input  logic [AW-1:0]   i_lsu_cmd_addr,
    input  logic            i_lsu_cmd_read,
    input  logic [DW-1:0]   i_lsu_cmd_wdata,
    input  logic [DW/8-1:0] i_lsu_cmd_wmask,
    output logic            o_lsu_cmd_ready,
    output logic            o_lsu_rsp_valid,
    output logic            o_lsu_rsp_err,
    output logic [DW-1:0]   o_lsu_rsp_rdata,
    output logic            o_vrb_cmd_valid,
    output logic [AW-1:0]   o_vrb_cmd_addr,
    output logic            o_vrb_cmd_read,
    output logic [DW-1:0]   o_vrb_cmd_wdata,
    output logic [DW/8-1:0] o_vrb_cmd_wmask,
    input  logic            i_vrb_rsp_valid,
    input  logic            i_vrb_rsp_err,
    input  logic [DW-1:0]   i_vrb_rsp_rdata,
    output logic            o_timeout
);

    localparam logic [TO_W-1:0] TO_MAX = '1;

    state_t          r_state, w_state_nxt;
    master_t         r_owner, w_owner_nxt;
    logic [TO_W-1:0] r_cnt,   w_cnt_nxt;
`ifdef VRB_ARB_RR_EN
    master_t         r_last,  w_last_nxt;
`endif

    logic            w_busy, w_rsp, w_to, w_done, w_window;
    logic            w_gnt_ifu, w_gnt_lsu;
    logic            w_rsp_err;
    logic [DW-1:0]   w_rsp_rdata;

    // Everything is gated by rst so a transaction abandoned by reset
    // cannot leak a response or a grant during the reset cycle.
    assign w_busy   = !rst && (r_state == ST_WAIT);
    assign w_rsp    = w_busy && i_vrb_rsp_valid;
    // A real response in the limit cycle wins over the timeout.
    assign w_to     = w_busy && !i_vrb_rsp_valid && (r_cnt == TO_MAX);
    assign w_done   = w_rsp || w_to;
    assign w_window = !rst && ((r_state == ST_IDLE) || w_done);

    vrb_arb_pick u_pick (
        .i_ifu_req (i_ifu_cmd_valid),
        .i_lsu_req (i_lsu_cmd_valid),
        .i_window  (w_window),
`ifdef VRB_ARB_RR_EN
        .i_last    (r_last),
`endif
        .o_gnt_ifu (w_gnt_ifu),
        .o_gnt_lsu (w_gnt_lsu)
    );

    assign o_ifu_cmd_ready = w_gnt_ifu;
    assign o_lsu_cmd_ready = w_gnt_lsu;

    // Command mux: IFU commands are always reads with no write payload.
    always_comb begin
        o_vrb_cmd_valid = 1'b0;
        o_vrb_cmd_addr  = '0;
        o_vrb_cmd_read  = 1'b0;
        o_vrb_cmd_wdata = '0;
        o_vrb_cmd_wmask = '0;
        if (w_gnt_lsu) begin
            o_vrb_cmd_valid = 1'b1;
            o_vrb_cmd_addr  = i_lsu_cmd_addr;
            o_vrb_cmd_read  = i_lsu_cmd_read;
            o_vrb_cmd_wdata = i_lsu_cmd_wdata;
            o_vrb_cmd_wmask = i_lsu_cmd_wmask;
        end else if (w_gnt_ifu) begin
            o_vrb_cmd_valid = 1'b1;
            o_vrb_cmd_addr  = i_ifu_cmd_addr;
            o_vrb_cmd_read  = 1'b1;
        end
    end

    // Response routing: slave response passes through, timeout forces err with zero data.
    assign w_rsp_err   = w_rsp ? i_vrb_rsp_err : 1'b1;
    assign w_rsp_rdata = w_rsp ? i_vrb_rsp_rdata : '0;

    assign o_ifu_rsp_valid = w_done && (r_owner == M_IFU);
    assign o_ifu_rsp_err   = o_ifu_rsp_valid && w_rsp_err;
    assign o_ifu_rsp_rdata = o_ifu_rsp_valid ? w_rsp_rdata : '0;
    assign o_lsu_rsp_valid = w_done && (r_owner == M_LSU);
    assign o_lsu_rsp_err   = o_lsu_rsp_valid && w_rsp_err;
    assign o_lsu_rsp_rdata = o_lsu_rsp_valid ? w_rsp_rdata : '0;
    assign o_timeout       = w_to;

    // Next state: completion returns to IDLE unless the same cycle re-grants.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
`ifdef VRB_ARB_RR_EN
        w_last_nxt  = r_last;
`endif
        if (r_state == ST_WAIT) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_done) begin
            w_state_nxt = ST_IDLE;
        end
        if (w_gnt_ifu || w_gnt_lsu) begin
            w_state_nxt = ST_WAIT;
            w_owner_nxt = w_gnt_lsu ? M_LSU : M_IFU;
            w_cnt_nxt   = '0;
`ifdef VRB_ARB_RR_EN
            w_last_nxt  = w_gnt_lsu ? M_LSU : M_IFU;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= M_IFU;
            r_cnt   <= '0;
`ifdef VRB_ARB_RR_EN
            r_last  <= M_IFU;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef VRB_ARB_RR_EN
            r_last  <= w_last_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_vrb_arb.sv
// Self-checking bench for vrb_arb: directed vector table, hand sequences, random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_vrb_arb;

    localparam int TO_W   = 3;
    localparam int TO_MAX = (1 << TO_W) - 1;
`ifdef VRB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        i_ifu_cmd_valid;
    logic [31:0] i_ifu_cmd_addr;
    logic        o_ifu_cmd_ready, o_ifu_rsp_valid, o_ifu_rsp_err;
    logic [31:0] o_ifu_rsp_rdata;
    logic        i_lsu_cmd_valid;
    logic [31:0] i_lsu_cmd_addr;
    logic        i_lsu_cmd_read;
    logic [31:0] i_lsu_cmd_wdata;
    logic [3:0]  i_lsu_cmd_wmask;
    logic        o_lsu_cmd_ready, o_lsu_rsp_valid, o_lsu_rsp_err;
    logic [31:0] o_lsu_rsp_rdata;
    logic        o_vrb_cmd_valid;
    logic [31:0] o_vrb_cmd_addr;
    logic        o_vrb_cmd_read;
    logic [31:0] o_vrb_cmd_wdata;
    logic [3:0]  o_vrb_cmd_wmask;
    logic        i_vrb_rsp_valid, i_vrb_rsp_err;
    logic [31:0] i_vrb_rsp_rdata;
    logic        o_timeout;

    vrb_arb #(.AW(32), .DW(32), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .i_ifu_cmd_valid(i_ifu_cmd_valid), .i_ifu_cmd_addr(i_ifu_cmd_addr),
        .o_ifu_cmd_ready(o_ifu_cmd_ready), .o_ifu_rsp_valid(o_ifu_rsp_valid),
        .o_ifu_rsp_err(o_ifu_rsp_err), .o_ifu_rsp_rdata(o_ifu_rsp_rdata),
        .i_lsu_cmd_valid(i_lsu_cmd_valid), .i_lsu_cmd_addr(i_lsu_cmd_addr),
        .i_lsu_cmd_read(i_lsu_cmd_read), .i_lsu_cmd_wdata(i_lsu_cmd_wdata),
        .i_lsu_cmd_wmask(i_lsu_cmd_wmask), .o_lsu_cmd_ready(o_lsu_cmd_ready),
        .o_lsu_rsp_valid(o_lsu_rsp_valid), .o_lsu_rsp_err(o_lsu_rsp_err),
        .o_lsu_rsp_rdata(o_lsu_rsp_rdata),
        .o_vrb_cmd_valid(o_vrb_cmd_valid), .o_vrb_cmd_addr(o_vrb_cmd_addr),
        .o_vrb_cmd_read(o_vrb_cmd_read), .o_vrb_cmd_wdata(o_vrb_cmd_wdata),
        .o_vrb_cmd_wmask(o_vrb_cmd_wmask),
        .i_vrb_rsp_valid(i_vrb_rsp_valid), .i_vrb_rsp_err(i_vrb_rsp_err),
        .i_vrb_rsp_rdata(i_vrb_rsp_rdata),
        .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        lr;
        logic [31:0] lwd;
        logic [3:0]  lwm;
        logic        rv;
        logic        re;
        logic [31:0] rd;
    } in_t;

    typedef struct {
        in_t         i;
        logic [3:0]  ctl;    // {ifu_ready, lsu_ready, cmd_valid, timeout}
        logic [2:0]  rsp;    // {ifu_rsp_valid, lsu_rsp_valid, err}
        logic [31:0] rdata;  // data seen by whichever master is answered
        logic [31:0] caddr;  // slave command address
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the set of outstanding transactions (0 or 1 entries),
    // the cycle each was granted in, and who was granted most recently.
    bit m_q[$];          // owner of outstanding transaction, 1 = LSU
    int m_cyc  = 0;
    int m_gcyc = 0;
    bit m_last = 1'b0;   // 1 = LSU granted last

    function automatic in_t mk(bit r, bit iv, logic [31:0] ia, bit lv, logic [31:0] la,
                               bit lr, logic [31:0] wd, logic [3:0] wm,
                               bit rv, bit re, logic [31:0] rd);
        in_t v;
        v.rst = r; v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.lr = lr;
        v.lwd = wd; v.lwm = wm; v.rv = rv; v.re = re; v.rd = rd;
        return v;
    endfunction

    function automatic in_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic in_t rspv(logic [31:0] rd, bit re);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, re, rd);
    endfunction

    function automatic vec_t mkv(in_t i, logic [3:0] ctl, logic [2:0] rsp,
                                 logic [31:0] rdata, logic [31:0] caddr);
        vec_t v;
        v.i = i; v.ctl = ctl; v.rsp = rsp; v.rdata = rdata; v.caddr = caddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [140:0] act, input logic [140:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then compare every output against the model.
    task automatic step(input in_t v);
        logic        e_ir, e_lr, e_cv, e_cr, e_iv, e_ie, e_lv, e_le, e_to;
        logic [31:0] e_ca, e_cw, e_id, e_ld;
        logic [3:0]  e_cm;
        bit          busy, own, rsp, to, open, lsu_wins, gi, gl;
        logic [140:0] e, a;
        rst = v.rst;
        i_ifu_cmd_valid = v.iv; i_ifu_cmd_addr = v.ia;
        i_lsu_cmd_valid = v.lv; i_lsu_cmd_addr = v.la; i_lsu_cmd_read = v.lr;
        i_lsu_cmd_wdata = v.lwd; i_lsu_cmd_wmask = v.lwm;
        i_vrb_rsp_valid = v.rv; i_vrb_rsp_err = v.re; i_vrb_rsp_rdata = v.rd;
        #4;
        {e_ir, e_lr, e_cv, e_cr, e_iv, e_ie, e_lv, e_le, e_to} = '0;
        {e_ca, e_cw, e_id, e_ld} = '0;
        e_cm = '0;
        if (v.rst) begin
            m_q.delete();
            m_last = 1'b0;
        end else begin
            busy = (m_q.size() != 0);
            own  = busy ? m_q[0] : 1'b0;
            rsp  = busy && v.rv;
            to   = busy && !v.rv && ((m_cyc - m_gcyc) == TO_MAX + 1);
            if (rsp || to) begin
                if (own) begin
                    e_lv = 1'b1; e_le = rsp ? v.re : 1'b1; e_ld = rsp ? v.rd : 32'h0;
                end else begin
                    e_iv = 1'b1; e_ie = rsp ? v.re : 1'b1; e_id = rsp ? v.rd : 32'h0;
                end
                e_to = to;
                void'(m_q.pop_front());
            end
            open     = !busy || rsp || to;
            lsu_wins = (v.lv && v.iv) ? (RR ? !m_last : 1'b1) : v.lv;
            gl = open && lsu_wins;
            gi = open && v.iv && !lsu_wins;
            if (gl) begin
                e_lr = 1'b1; e_cv = 1'b1; e_ca = v.la; e_cr = v.lr; e_cw = v.lwd; e_cm = v.lwm;
            end
            if (gi) begin
                e_ir = 1'b1; e_cv = 1'b1; e_ca = v.ia; e_cr = 1'b1;
            end
            if (gl || gi) begin
                m_q.push_back(gl);
                m_gcyc = m_cyc;
                m_last = gl;
            end
        end
        m_cyc++;
        e = {e_ir, e_lr, e_cv, e_ca, e_cr, e_cw, e_cm, e_iv, e_ie, e_id, e_lv, e_le, e_ld, e_to};
        a = {o_ifu_cmd_ready, o_lsu_cmd_ready, o_vrb_cmd_valid, o_vrb_cmd_addr, o_vrb_cmd_read,
             o_vrb_cmd_wdata, o_vrb_cmd_wmask, o_ifu_rsp_valid, o_ifu_rsp_err, o_ifu_rsp_rdata,
             o_lsu_rsp_valid, o_lsu_rsp_err, o_lsu_rsp_rdata, o_timeout};
        chk("model", a, e);
    endtask

    vec_t tbl[$];
    in_t  w;

    initial begin
        rst = 1'b1;
        i_ifu_cmd_valid = 0; i_ifu_cmd_addr = 0;
        i_lsu_cmd_valid = 0; i_lsu_cmd_addr = 0; i_lsu_cmd_read = 0;
        i_lsu_cmd_wdata = 0; i_lsu_cmd_wmask = 0;
        i_vrb_rsp_valid = 0; i_vrb_rsp_err = 0; i_vrb_rsp_rdata = 0;

        // Reset held with requests and a stray response: everything stays 0.
        tbl.push_back(mkv(mk(1, 1, 'h10, 1, 'h20, 1, 0, 0, 1, 1, 'h55), 4'b0000, 3'b000, 0, 0));
        // IFU read 0x100, slave answers two cycles after the grant.
        tbl.push_back(mkv(mk(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0), 4'b1010, 3'b000, 0, 'h100));
        tbl.push_back(mkv(nop(), 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mkv(rspv('hDEADBEEF, 0), 4'b0000, 3'b100, 'hDEADBEEF, 0));
        tbl.push_back(mkv(nop(), 4'b0000, 3'b000, 0, 0));
        // LSU read 0x300 with no answer: timeout after 7 quiet WAIT cycles, late rsp dropped.
        tbl.push_back(mkv(mk(0, 0, 0, 1, 'h300, 1, 0, 0, 0, 0, 0), 4'b0110, 3'b000, 0, 'h300));
        for (int k = 0; k < TO_MAX; k++) tbl.push_back(mkv(nop(), 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mkv(nop(), 4'b0001, 3'b011, 0, 0));
        tbl.push_back(mkv(rspv('h1234, 0), 4'b0000, 3'b000, 0, 0));
        // Contention after reset: LSU write 0x200 first, IFU granted as the LSU response lands.
        tbl.push_back(mkv(mk(1, 1, 'h104, 0, 0, 0, 0, 0, 0, 0, 0), 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mkv(mk(0, 1, 'h104, 1, 'h200, 0, 'hCAFEF00D, 4'hF, 0, 0, 0),
                          4'b0110, 3'b000, 0, 'h200));
        tbl.push_back(mkv(mk(0, 1, 'h104, 0, 0, 0, 0, 0, 0, 0, 0), 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mkv(mk(0, 1, 'h104, 0, 0, 0, 0, 0, 1, 0, 0), 4'b1010, 3'b010, 0, 'h104));
        tbl.push_back(mkv(rspv('hA5A5A5A5, 0), 4'b0000, 3'b100, 'hA5A5A5A5, 0));
        tbl.push_back(mkv(nop(), 4'b0000, 3'b000, 0, 0));
        // Reset during WAIT: the later response is dropped, next request granted normally.
        tbl.push_back(mkv(mk(0, 1, 'h400, 0, 0, 0, 0, 0, 0, 0, 0), 4'b1010, 3'b000, 0, 'h400));
        tbl.push_back(mkv(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mkv(rspv('h77, 0), 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mkv(mk(0, 1, 'h404, 0, 0, 0, 0, 0, 0, 0, 0), 4'b1010, 3'b000, 0, 'h404));
        tbl.push_back(mkv(rspv('h99, 1), 4'b0000, 3'b101, 'h99, 0));
        // Response arriving exactly in the timeout cycle wins; no timeout pulse.
        tbl.push_back(mkv(mk(0, 0, 0, 1, 'h500, 1, 0, 0, 0, 0, 0), 4'b0110, 3'b000, 0, 'h500));
        for (int k = 0; k < TO_MAX; k++) tbl.push_back(mkv(nop(), 4'b0000, 3'b000, 0, 0));
        tbl.push_back(mkv(rspv('hBEEF, 0), 4'b0000, 3'b010, 'hBEEF, 0));
        tbl.push_back(mkv(nop(), 4'b0000, 3'b000, 0, 0));

        tick();
        foreach (tbl[i]) begin
            step(tbl[i].i);
            chk($sformatf("ctl[%0d]", i),
                141'({o_ifu_cmd_ready, o_lsu_cmd_ready, o_vrb_cmd_valid, o_timeout}),
                141'(tbl[i].ctl));
            chk($sformatf("rsp[%0d]", i),
                141'({o_ifu_rsp_valid, o_lsu_rsp_valid, o_ifu_rsp_err | o_lsu_rsp_err}),
                141'(tbl[i].rsp));
            chk($sformatf("rdata[%0d]", i), 141'(o_ifu_rsp_rdata | o_lsu_rsp_rdata),
                141'(tbl[i].rdata));
            chk($sformatf("caddr[%0d]", i), 141'(o_vrb_cmd_addr), 141'(tbl[i].caddr));
            tick();
        end

        // Back-to-back IFU reads against a 1-cycle slave that echoes the address.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        step(mk(0, 1, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("b2b_first_rdy", 141'(o_ifu_cmd_ready), 141'(1));
        tick();
        for (int k = 1; k <= 4; k++) begin
            step(mk(0, k < 4, 32'h1000 + 32'(4 * k), 0, 0, 0, 0, 0,
                    1, 0, 32'h1000 + 32'(4 * (k - 1))));
            chk($sformatf("b2b_rdy%0d", k), 141'(o_ifu_cmd_ready), 141'(k < 4));
            chk($sformatf("b2b_rsp%0d", k), 141'({o_ifu_rsp_valid, o_ifu_rsp_rdata}),
                141'({1'b1, 32'h1000 + 32'(4 * (k - 1))}));
            tick();
        end
        step(nop()); tick();

        // Sustained contention: LSU first, then RR alternates while fixed priority keeps LSU.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        step(mk(0, 1, 'h600, 1, 'h700, 1, 0, 0, 0, 0, 0));
        chk("cont0_lsu", 141'({o_ifu_cmd_ready, o_lsu_cmd_ready}), 141'(2'b01));
        tick();
        step(mk(0, 1, 'h600, 1, 'h704, 1, 0, 0, 1, 0, 'h1));
        chk("cont1", 141'({o_ifu_cmd_ready, o_lsu_cmd_ready}), 141'({RR, !RR}));
        tick();
        step(mk(0, 1, 'h604, 1, 'h708, 1, 0, 0, 1, 0, 'h2));
        chk("cont2", 141'({o_ifu_cmd_ready, o_lsu_cmd_ready}), 141'(2'b01));
        tick();
        step(rspv('h3, 0)); tick();
        step(nop()); tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            w = mk($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom,
                   $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                   $urandom, 4'($urandom), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom);
            step(w);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
